// File: rtl/pipe_if_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_if_pkg                                                        |
// | Shared encodings and types for the queued instruction-fetch stage. |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
package pipe_if_pkg;

  // Next-PC source encoding shared with the legacy combinational IF stage
  localparam logic [2:0] PC_SEL_J   = 3'b000;
  localparam logic [2:0] PC_SEL_R   = 3'b001;
  localparam logic [2:0] PC_SEL_SEQ = 3'b010;
  localparam logic [2:0] PC_SEL_B   = 3'b100;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One fetch-queue slot at the default machine width
  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] pc4;
    logic [XLEN_DEFAULT-1:0] instr;
  } fq_entry_t;

  // Only the three jump/branch codes redirect; every other code is sequential
  function automatic logic is_redirect(input logic [2:0] sel);
    return (sel == PC_SEL_J) || (sel == PC_SEL_R) || (sel == PC_SEL_B);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_if_queue_fetch_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_fifo                                                         |
// | Synchronous FIFO for fetched entries; flush beats push and pop.    |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module fetch_fifo
  import pipe_if_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type ENTRY_T = fq_entry_t
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 flush,
  input  ENTRY_T               wdata,
  output ENTRY_T               rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                 full,
  output logic                 empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  ENTRY_T        mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush & ~empty;
  assign rdata   = mem[rptr];

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage needs no reset: occupancy decides what is visible
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/pipe_if_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_if_queue                                                      |
// | Instruction fetch: PC select, 1-cycle imem read, fetch queue with  |
// | valid/ready toward decode and same-cycle bypass when empty.        |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module pipe_if_queue
  import pipe_if_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int               FQ_DEPTH = 4,
  parameter int               IMEM_AW  = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              pc_mux_sel,
  input  logic [XLEN-1:0]         j_pc,
  input  logic [XLEN-1:0]         r_pc,
  input  logic [XLEN-1:0]         b_pc,
  input  logic                    halt,
  output logic                    imem_req,
  output logic [IMEM_AW-1:0]      imem_addr,
  input  logic [XLEN-1:0]         imem_rdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_pc,
  output logic [XLEN-1:0]         out_pc4,
  output logic [XLEN-1:0]         out_instr,
  output logic [$clog2(FQ_DEPTH):0] fq_count
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] tag_pc;
  logic [XLEN-1:0] sel_src;
  logic [XLEN-1:0] target;
  logic            inflight;
  logic            redirect;
  logic            credit;
  logic [CW:0]     occupancy;
  logic            pop;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  entry_t          incoming;
  entry_t          fifo_head;
  entry_t          head;

  assign redirect = is_redirect(pc_mux_sel);

  // Redirect target from the selected source, forced to word alignment
  always_comb begin
    sel_src = b_pc;
    case (pc_mux_sel)
      PC_SEL_J: sel_src = j_pc;
      PC_SEL_R: sel_src = r_pc;
      default:  sel_src = b_pc;
    endcase
    target = {sel_src[XLEN-1:2], 2'b00};
  end

  // A slot is reserved for the outstanding read, so the queue can never overflow
  assign occupancy = {1'b0, fq_count} + {{CW{1'b0}}, inflight};
  assign credit    = occupancy < (CW+1)'(FQ_DEPTH);
  assign imem_req  = ~rst & ~halt & ~redirect & credit;
  assign imem_addr = pc[IMEM_AW+1:2];

  assign incoming.pc    = tag_pc;
  assign incoming.pc4   = tag_pc + XLEN'(4);
  assign incoming.instr = imem_rdata;

  // An arriving response is shown directly when the queue is empty
  assign out_valid = ~rst & ~redirect & (~fifo_empty | inflight);
  assign head      = fifo_empty ? incoming : fifo_head;
  assign out_pc    = head.pc;
  assign out_pc4   = head.pc4;
  assign out_instr = head.instr;

  assign pop       = out_valid & out_ready;
  assign fifo_push = inflight & ~redirect & ~(fifo_empty & pop);
  assign fifo_pop  = pop & ~fifo_empty;

  // PC advance, redirect and in-flight tag tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      tag_pc   <= '0;
      inflight <= 1'b0;
    end else if (redirect) begin
      pc       <= target;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        tag_pc <= pc;
        pc     <= pc + XLEN'(4);
      end
    end
  end

  fetch_fifo #(
    .DEPTH   (FQ_DEPTH),
    .ENTRY_T (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect),
    .wdata (incoming),
    .rdata (fifo_head),
    .count (fq_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A push into a full queue must coincide with a pop
  assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_full && !fifo_pop));

endmodule
`default_nettype wire

// File: tb/tb_pipe_if_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pipe_if_queue                                                   |
// | Randomised bench with a queue-based reference model of the fetch   |
// | stage, plus a second instance checking a wrapping reset PC.        |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module tb_pipe_if_queue;
  import pipe_if_pkg::*;

  localparam int          DEPTH = 4;
  localparam int          AW    = 11;
  localparam int          CW    = 3;
  localparam logic [31:0] RST2  = 32'hFFFF_FFF8;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    sel;
  logic [31:0]   j_pc, r_pc, b_pc;
  logic          halt, out_ready;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          out_valid;
  logic [31:0]   out_pc, out_pc4, out_instr;
  logic [CW-1:0] fq_count;

  logic          req2;
  logic [AW-1:0] addr2;
  logic [31:0]   rdata2;
  logic          valid2;
  logic [31:0]   pc2, pc4_2, instr2;
  logic [CW-1:0] count2;

  int            n_tests, n_fail, since_rst;
  bit            dut2_chk;

  // Reference model state: next fetch PC, outstanding request, queued PCs
  logic [31:0]   m_pc, m_tag;
  bit            m_inflight;
  logic [31:0]   m_q[$];

  always #5 clk = ~clk;

  pipe_if_queue dut (
    .clk(clk), .rst(rst), .pc_mux_sel(sel), .j_pc(j_pc), .r_pc(r_pc), .b_pc(b_pc),
    .halt(halt), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_pc4(out_pc4),
    .out_instr(out_instr), .fq_count(fq_count)
  );

  pipe_if_queue #(.RESET_PC(RST2)) dut2 (
    .clk(clk), .rst(rst), .pc_mux_sel(PC_SEL_SEQ), .j_pc(32'h0), .r_pc(32'h0), .b_pc(32'h0),
    .halt(1'b0), .imem_req(req2), .imem_addr(addr2), .imem_rdata(rdata2),
    .out_valid(valid2), .out_ready(1'b1), .out_pc(pc2), .out_pc4(pc4_2),
    .out_instr(instr2), .fq_count(count2)
  );

  // Instruction memories: word at address a holds a*4+1
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= ({21'b0, imem_addr} << 2) | 32'd1;
    if (req2)     rdata2     <= ({21'b0, addr2} << 2) | 32'd1;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return {19'b0, pc[12:2], 2'b01};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; sel = PC_SEL_SEQ; halt = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_count", fq_count, 0);
    @(posedge clk);
    m_q.delete(); m_inflight = 0; m_pc = 32'h0; m_tag = 32'h0;
    since_rst = 0;
  endtask

  task automatic step(input logic [2:0] s, input logic [31:0] jt, input logic [31:0] rt,
                      input logic [31:0] bt, input logic h, input logic rdy);
    logic [31:0] tgt, head, exp2;
    bit          redir, cred, req, vld, pop, was_empty;
    @(negedge clk);
    rst = 1'b0; sel = s; j_pc = jt; r_pc = rt; b_pc = bt; halt = h; out_ready = rdy;
    #1;
    redir = (s == 3'b000) || (s == 3'b001) || (s == 3'b100);
    tgt   = (s == 3'b000 ? jt : (s == 3'b001 ? rt : bt)) & 32'hFFFF_FFFC;
    cred  = (m_q.size() + int'(m_inflight)) < DEPTH;
    req   = !h && !redir && cred;
    vld   = !redir && (m_q.size() > 0 || m_inflight);
    head  = (m_q.size() > 0) ? m_q[0] : m_tag;
    chk("imem_req", imem_req, req);
    if (req) chk("imem_addr", imem_addr, (m_pc >> 2) & 32'h7FF);
    chk("fq_count", fq_count, m_q.size());
    chk("out_valid", out_valid, vld);
    if (vld) begin
      chk("out_pc", out_pc, head);
      chk("out_pc4", out_pc4, head + 32'd4);
      chk("out_instr", out_instr, mem_word(head));
    end
    if (dut2_chk) begin
      if (since_rst == 0) chk("r2_valid0", valid2, 0);
      else if (since_rst <= 3) begin
        exp2 = RST2 + 32'(4 * (since_rst - 1));
        chk("r2_valid", valid2, 1);
        chk("r2_pc", pc2, exp2);
        chk("r2_pc4", pc4_2, exp2 + 32'd4);
        chk("r2_instr", instr2, mem_word(exp2));
        chk("r2_count", count2, 0);
      end
    end
    @(posedge clk);
    pop = vld && rdy;
    if (redir) begin
      m_q.delete(); m_inflight = 0; m_pc = tgt;
    end else begin
      was_empty = (m_q.size() == 0);
      if (pop && !was_empty) void'(m_q.pop_front());
      if (m_inflight && !(pop && was_empty)) m_q.push_back(m_tag);
      m_inflight = req;
      if (req) begin m_tag = m_pc; m_pc = m_pc + 32'd4; end
    end
    since_rst++;
  endtask

  logic [2:0] ill_codes [4];
  logic [2:0] red_codes [3];

  initial begin
    logic [2:0] s;
    int         r, k;
    ill_codes = '{3'b011, 3'b101, 3'b110, 3'b111};
    red_codes = '{3'b000, 3'b001, 3'b100};
    rst = 1'b0; sel = PC_SEL_SEQ; j_pc = 0; r_pc = 0; b_pc = 0; halt = 0; out_ready = 1;
    n_tests = 0; n_fail = 0; dut2_chk = 0; since_rst = 0;

    do_reset();
    repeat (12) step(PC_SEL_SEQ, 0, 0, 0, 0, 1);
    // decode stalls long enough to fill the queue
    repeat (10) step(PC_SEL_SEQ, 0, 0, 0, 0, 0);
    #1;
    chk("stall_full", fq_count, 4);
    chk("stall_noreq", imem_req, 0);
    repeat (8) step(PC_SEL_SEQ, 0, 0, 0, 0, 1);
    // two held entries plus one in flight, then a jump
    repeat (2) step(PC_SEL_SEQ, 0, 0, 0, 0, 0);
    step(PC_SEL_J, 32'h0000_0103, 0, 0, 0, 1);
    repeat (6) step(PC_SEL_SEQ, 0, 0, 0, 0, 1);
    // illegal code 111 must act as sequential
    repeat (6) step(3'b111, 0, 0, $urandom, 0, 1);
    // wrap through the top of the address space
    step(PC_SEL_B, 0, 0, 32'hFFFF_FFF9, 0, 1);
    repeat (6) step(PC_SEL_SEQ, 0, 0, 0, 0, 1);
    // reset with a busy queue and an outstanding read
    repeat (3) step(PC_SEL_SEQ, 0, 0, 0, 0, 0);
    do_reset();
    repeat (5) step(PC_SEL_SEQ, 0, 0, 0, 0, 1);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) do_reset();
      else begin
        k = $urandom_range(0, 9);
        if (k < 6)      s = PC_SEL_SEQ;
        else if (k < 8) s = ill_codes[$urandom_range(0, 3)];
        else            s = red_codes[$urandom_range(0, 2)];
        step(s, $urandom, $urandom, $urandom, $urandom_range(0, 9) == 0,
             $urandom_range(0, 9) < 7);
      end
    end

    dut2_chk = 1;
    do_reset();
    repeat (5) step(PC_SEL_SEQ, 0, 0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
